// File: rtl/ps2_cmd_pkg.sv
// Shared definitions for the PS/2 keypad command controller: scancodes, FSM and key-class encodings.
// Also holds the BCD-to-binary helper used when an entry is committed.
package ps2_cmd_pkg;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_COMMIT,
    ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    KEY_DIGIT,
    KEY_ENTER,
    KEY_BKSP,
    KEY_ESC,
    KEY_OTHER
  } key_class_t;

  // Three BCD digits {d2,d1,d0} -> 100*d2 + 10*d1 + d0; 999 fits in 10 bits.
  function automatic logic [9:0] bcd_to_bin(input logic [11:0] bcd);
    return 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/ps2_key_decode.sv
// Combinational scancode classifier: maps a set-2 make code to a key class and digit value.
// Zero latency, no flow control; digit is 0 for any non-digit key.
module ps2_key_decode
  import ps2_cmd_pkg::*;
(
  input  logic [7:0] dato,
  output key_class_t key_cls,
  output logic [3:0] digit
);

  always_comb begin
    key_cls = KEY_OTHER;
    digit   = 4'd0;
    case (dato)
      SC_0:     begin key_cls = KEY_DIGIT; digit = 4'd0; end
      SC_1:     begin key_cls = KEY_DIGIT; digit = 4'd1; end
      SC_2:     begin key_cls = KEY_DIGIT; digit = 4'd2; end
      SC_3:     begin key_cls = KEY_DIGIT; digit = 4'd3; end
      SC_4:     begin key_cls = KEY_DIGIT; digit = 4'd4; end
      SC_5:     begin key_cls = KEY_DIGIT; digit = 4'd5; end
      SC_6:     begin key_cls = KEY_DIGIT; digit = 4'd6; end
      SC_7:     begin key_cls = KEY_DIGIT; digit = 4'd7; end
      SC_8:     begin key_cls = KEY_DIGIT; digit = 4'd8; end
      SC_9:     begin key_cls = KEY_DIGIT; digit = 4'd9; end
      SC_ENTER: key_cls = KEY_ENTER;
      SC_BKSP:  key_cls = KEY_BKSP;
      SC_ESC:   key_cls = KEY_ESC;
      default:  ;
    endcase
  end

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// Keypad setpoint entry: up to 3 BCD digits, Enter commits (sp_load one cycle after Enter is sampled), out-of-range -> ERROR hold.
// No backpressure: keys qualified by tick&correct&en. Optional ENTRY inactivity timeout via CMD_CTRL_TIMEOUT_EN.
module ps2_cmd_ctrl
  import ps2_cmd_pkg::*;
#(
  parameter int MAX_VAL     = 99,
  parameter int ERR_HOLD    = 50_000_000,
  parameter int TIMEOUT_CYC = 250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  dato,
  input  logic        tick,
  input  logic        correct,
  output logic [7:0]  setpoint,
  output logic        sp_load,
  output logic [11:0] entry_bcd,
  output logic [1:0]  entry_cnt,
  output logic        err,
  output logic        busy
);

  localparam int         ERR_W    = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_HOLD - 1);
  localparam logic [9:0] MAX_V    = 10'(MAX_VAL);

`ifdef CMD_CTRL_TIMEOUT_EN
  localparam int         TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0]  to_cnt_q;
`endif

  state_t           state_q;
  logic [7:0]       setpoint_q;
  logic             sp_load_q;
  logic [11:0]      bcd_q;
  logic [1:0]       cnt_q;
  logic [ERR_W-1:0] err_cnt_q;

  key_class_t       key_cls;
  logic [3:0]       key_digit;
  logic             key_vld_d;
  logic [9:0]       value_d;

  ps2_key_decode u_key_decode (
    .dato    (dato),
    .key_cls (key_cls),
    .digit   (key_digit)
  );

  assign key_vld_d = tick & correct & en;
  assign value_d   = bcd_to_bin(bcd_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      setpoint_q <= 8'd0;
      sp_load_q  <= 1'b0;
      bcd_q      <= 12'd0;
      cnt_q      <= 2'd0;
      err_cnt_q  <= '0;
`ifdef CMD_CTRL_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      sp_load_q <= 1'b0;
`ifdef CMD_CTRL_TIMEOUT_EN
      if (state_q != ST_ENTRY || key_vld_d) to_cnt_q <= '0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (key_vld_d && key_cls == KEY_DIGIT) begin
            bcd_q   <= {8'd0, key_digit};
            cnt_q   <= 2'd1;
            state_q <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (key_vld_d) begin
            case (key_cls)
              KEY_DIGIT: begin
                if (cnt_q != 2'd3) begin
                  bcd_q <= {bcd_q[7:0], key_digit};
                  cnt_q <= cnt_q + 2'd1;
                end
              end
              KEY_BKSP: begin
                bcd_q <= {4'd0, bcd_q[11:4]};
                cnt_q <= cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_q <= ST_IDLE;
              end
              KEY_ESC: begin
                bcd_q   <= 12'd0;
                cnt_q   <= 2'd0;
                state_q <= ST_IDLE;
              end
              KEY_ENTER: state_q <= ST_COMMIT;
              default: ;
            endcase
          end
`ifdef CMD_CTRL_TIMEOUT_EN
          // Counting only while enabled keeps a paused entry alive.
          else if (en) begin
            if (to_cnt_q == TO_LAST) begin
              bcd_q     <= 12'd0;
              cnt_q     <= 2'd0;
              err_cnt_q <= '0;
              state_q   <= ST_ERROR;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
`endif
        end
        ST_COMMIT: begin
          bcd_q <= 12'd0;
          cnt_q <= 2'd0;
          if (value_d <= MAX_V) begin
            setpoint_q <= value_d[7:0];
            sp_load_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            err_cnt_q <= '0;
            state_q   <= ST_ERROR;
          end
        end
        ST_ERROR: begin
          if (err_cnt_q == ERR_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            err_cnt_q <= err_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign setpoint  = setpoint_q;
  assign sp_load   = sp_load_q;
  assign entry_bcd = bcd_q;
  assign entry_cnt = cnt_q;
  assign err       = (state_q == ST_ERROR);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/ps2_cmd_ctrl.md
PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

Interface
REQ-001 SHALL provide parameter MAX_VAL, default 99: highest setpoint accepted on commit.
REQ-002 SHALL provide parameter ERR_HOLD, default 50_000_000: cycles spent in ERROR before returning to IDLE.
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 250_000_000: entry inactivity limit in cycles (used only with CMD_CTRL_TIMEOUT_EN).
REQ-004 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: high enables key acceptance.
REQ-007 SHALL have port dato, input, 8: PS/2 set-2 make code, already filtered of break codes.
REQ-008 SHALL have port tick, input, 1: one-cycle strobe, dato valid.
REQ-009 SHALL have port correct, input, 1: frame parity/stop OK, qualifies tick.
REQ-010 SHALL have port setpoint, output, 8: committed binary setpoint.
REQ-011 SHALL have port sp_load, output, 1: one-cycle pulse when setpoint updates.
REQ-012 SHALL have port entry_bcd, output, 12: three BCD digits being typed, for the display mux.
REQ-013 SHALL have port entry_cnt, output, 2: number of digits held, 0..3.
REQ-014 SHALL have port err, output, 1: high while in ERROR.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL accept a key only in a cycle where tick=1, correct=1 and en=1; all other ticks are ignored with no state change.
REQ-017 SHALL classify keys as follows.
  - Digits: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
  - Commands: Enter 0x5A, Backspace 0x66, Esc 0x76.
  - Any other code: ignored.
REQ-018 SHALL implement the FSM states IDLE, ENTRY, COMMIT, ERROR.
REQ-019 IDLE SHALL react to keys as follows.
  - Digit: load it into the least significant digit, set entry_cnt=1, go to ENTRY.
  - Enter, Backspace, Esc: ignored.
REQ-020 ENTRY SHALL react to a digit as follows.
  - entry_cnt<3: shift entry_bcd left by 4 bits and insert the digit at bits [3:0]; entry_cnt+1.
  - entry_cnt=3: digit ignored.
REQ-021 ENTRY SHALL react to Backspace by shifting entry_bcd right by 4 bits and decrementing entry_cnt; at entry_cnt=0, go to IDLE.
REQ-022 ENTRY SHALL react to Esc by clearing entry_bcd and entry_cnt and going to IDLE.
REQ-023 ENTRY SHALL react to Enter by going to COMMIT.
REQ-024 COMMIT SHALL last exactly one cycle and compute value = 100*d2 + 10*d1 + d0 at 10-bit width.
REQ-025 COMMIT SHALL branch on the computed value.
  - value <= MAX_VAL: setpoint <= value[7:0], sp_load=1 for that cycle, clear the entry, go to IDLE.
  - Otherwise: clear the entry, go to ERROR.
REQ-026 sp_load SHALL rise exactly one clock after the cycle in which Enter was accepted.
REQ-027 ERROR SHALL ignore all keys, count ERR_HOLD cycles, then go to IDLE; err=1 throughout ERROR.
REQ-028 en deasserted mid-entry SHALL freeze state and buffer; no timeout counting occurs while en=0.
REQ-029 setpoint SHALL change only in COMMIT.

Reset
REQ-030 Asserting rst SHALL immediately force the following, regardless of state:
  - state=IDLE;
  - setpoint=0, entry_bcd=0, entry_cnt=0;
  - sp_load=0, err=0, busy=0;
  - all counters cleared.
REQ-031 rst asserted mid-entry or mid-ERROR SHALL discard the partial entry with no sp_load.

Configuration
REQ-032 With macro CMD_CTRL_TIMEOUT_EN defined, the ENTRY inactivity timeout SHALL be compiled in.
  - The counter restarts on every accepted key.
  - Reaching TIMEOUT_CYC clears the entry and goes to ERROR.
REQ-033 Without CMD_CTRL_TIMEOUT_EN, the timeout counter SHALL be absent and ENTRY SHALL wait indefinitely.

Structure
REQ-034 Shared package ps2_cmd_pkg SHALL hold the scancode constants, the FSM state encoding and the key-class encoding (DIGIT, ENTER, BKSP, ESC, OTHER).
REQ-035 Scancode classification SHALL live in the combinational sub-module ps2_key_decode (inputs dato; outputs key class and 4-bit digit value), instantiated once.

Verification
REQ-036 Keys 1,2,Enter with MAX_VAL=99 -> sp_load pulse one cycle after the Enter tick, setpoint=12, state IDLE.
REQ-037 Keys 1,0,0,Enter with MAX_VAL=99 -> no sp_load, err=1 for ERR_HOLD cycles, setpoint unchanged.
REQ-038 Keys 4,5,6,7,Backspace,Enter with MAX_VAL=255 -> 7 ignored, Backspace leaves 45, setpoint=45.
REQ-039 Key 8 with correct=0, then key 8 with en=0 -> entry_cnt stays 0, busy=0.
REQ-040 Keys 9,Esc,Enter -> no sp_load, entry_bcd=0, IDLE; rst pulse after 3,3 -> entry_cnt=0 and setpoint=0 immediately.
REQ-041 CMD_CTRL_TIMEOUT_EN with TIMEOUT_CYC=100: key 5 then 100 idle cycles -> ERROR, err=1, entry cleared.
